pwm_light_ctrl: RTL
===================

Name: pwm_light_ctrl

Overview:
- Sequencer for the PWM light datapath.
- Generates the free-running 10-bit PWM period counter from a clock prescaler.
- Selects one of five brightness levels from user button pulses, then fades the active duty value toward that level's duty at period boundaries.
- Drives the single PWM light output. Sits between the button-conditioning logic and the light pin.

Parameters:
- PRESCALE, 100, clocks per counter increment (100 MHz -> 1 MHz count -> 1 kHz PWM); legal range >=1.
- PERIOD, 1000, counter modulus; counter runs 0..PERIOD-1; legal range 2..1024.
- FADE_PERIODS, 4, PWM periods between fade steps; legal range >=1.
- FADE_STEP, 10, duty increment/decrement per fade step; legal range 1..PERIOD.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_btn_next  input  1  one-cycle pulse, already debounced; advance brightness level.
- i_btn_off  input  1  one-cycle pulse, already debounced; force level 0.
- o_counter  output  10  current PWM period counter.
- o_pwm  output  1  registered PWM light output.
- o_level  output  3  selected level, 0..4.
- o_duty  output  10  active duty currently applied.
- o_busy  output  1  high while the active duty differs from the target duty (fade in progress).

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-high.
- Reset values: all outputs 0; prescaler 0; fade-period count 0; target duty 0; FSM in IDLE.
- Prescaler and tick:
  - Prescaler counts 0..PRESCALE-1. A tick is asserted on the cycle the prescaler equals PRESCALE-1.
  - On a tick, o_counter increments. When o_counter = PERIOD-1 it wraps to 0; that tick is the "wrap".
- Level table (duty values): L0=0, L1=300, L2=400, L3=600, L4=990.
  - For any PERIOD != 1000, each table value is clamped to PERIOD.
  - The table is a constant function in the package.
- Buttons (registered, applied the cycle after the pulse):
  - i_btn_off sets level 0.
  - Otherwise i_btn_next sets level = (level==4) ? 0 : level+1.
  - Simultaneous pulses: off wins.
  - Target duty = table[level], updated the same cycle as o_level.
- PWM output: o_pwm <= (o_counter < o_duty), registered, one-cycle latency from o_counter.
  - Duty 0 gives constant low.
  - Duty >= PERIOD gives constant high.
- Duty update rule: o_duty changes only on a wrap, so no mid-period glitch.
- Fade FSM states:
  - IDLE: o_duty == target.
  - UP: o_duty < target.
  - DOWN: o_duty > target.
- FSM transitions:
  - The state is re-evaluated every cycle from the comparison of o_duty and target.
  - A target change mid-fade redirects immediately; there is no need to finish the current direction.
  - In UP/DOWN, the fade-period count increments on each wrap.
  - When the count reaches FADE_PERIODS-1 on a wrap:
    - count resets;
    - UP: o_duty = min(o_duty+FADE_STEP, target);
    - DOWN: o_duty = max(o_duty-FADE_STEP, target).
  - This step arithmetic uses 11-bit intermediates: no overshoot, no underflow wrap.
  - The count resets to 0 on entry to IDLE.
- o_busy = (state != IDLE).
- Reset asserted mid-fade or mid-period returns every register to its reset value asynchronously. There is no residual fade.

Decomposition:
- Package pwm_light_pkg:
  - LEVEL_NUM=5.
  - Counter width CNT_W=10.
  - Level width LVL_W=3.
  - Fade state enum {IDLE, UP, DOWN}.
  - Function level_duty(level, period) returning the clamped table value.
- Sub-module pwm_tick_gen (PRESCALE, PERIOD):
  - Prescaler plus period counter.
  - Outputs o_counter, o_tick and o_wrap.
- Top-level content: level register, fade FSM and PWM compare.

Test Plan:
1. Reset state: PRESCALE=1, PERIOD=1000; hold i_reset for 5 cycles, release -> o_counter increments by 1 per cycle from 0, wraps 999->0; o_pwm, o_level, o_duty and o_busy all remain 0.
2. Level stepping and fade up: FADE_STEP=100, FADE_PERIODS=1.
   - Pulse i_btn_next once -> o_level=1 next cycle, o_busy=1.
   - o_duty goes 100, 200, 300 on successive wraps, then o_busy=0.
   - o_pwm is high exactly 300 cycles per 1000-cycle period.
3. Level wrap and fade down: from level 4 with o_duty=990, pulse i_btn_next -> o_level=0; o_duty goes 890, 790, ..., 90, 0 on successive wraps (10 steps, no underflow); o_pwm then constant low.
4. Simultaneous buttons and mid-fade retarget:
   - From level 2 at steady duty 400, pulse i_btn_off and i_btn_next together -> o_level=0.
   - After o_duty reaches 200, pulse i_btn_next twice -> target 400; FSM redirects to UP, o_duty goes 300 then 400.
5. No mid-period glitch: with FADE_PERIODS=3 and a button pulse at o_counter=500 -> o_duty is unchanged until the third wrap after the target change; o_pwm pattern within each period is consistent with a single duty value.
6. Asynchronous reset mid-fade: assert i_reset between clock edges while o_busy=1 and o_duty=500 -> all outputs 0 immediately, without waiting for a clock edge; after release, behaviour matches scenario 1.

Source files
------------

// File: rtl/pwm_light_pkg.sv
// Shared widths, fade state encoding and the brightness level table for the PWM light path.
// Pure declarations; no latency and no backpressure.
package pwm_light_pkg;

  localparam int LEVEL_NUM = 5;
  localparam int CNT_W     = 10;
  localparam int LVL_W     = 3;

  typedef enum logic [1:0] {IDLE, UP, DOWN} fade_state_t;

  // Table values are clamped to the period so a short period saturates at full-on.
  function automatic logic [CNT_W-1:0] level_duty(input logic [LVL_W-1:0] level, input int period);
    int v;
    case (level)
      3'd1:    v = 300;
      3'd2:    v = 400;
      3'd3:    v = 600;
      3'd4:    v = 990;
      default: v = 0;
    endcase
    if (v > period) v = period;
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/pwm_light_ctrl_if.sv
// Button inputs and light/status outputs of the PWM light controller.
// Master is the controller side; slave is the button logic and light pin side.
interface pwm_light_ctrl_if;
  import pwm_light_pkg::*;

  logic             i_btn_next;
  logic             i_btn_off;
  logic [CNT_W-1:0] o_counter;
  logic             o_pwm;
  logic [LVL_W-1:0] o_level;
  logic [CNT_W-1:0] o_duty;
  logic             o_busy;

  modport master (
    input  i_btn_next, i_btn_off,
    output o_counter, o_pwm, o_level, o_duty, o_busy
  );

  modport slave (
    output i_btn_next, i_btn_off,
    input  o_counter, o_pwm, o_level, o_duty, o_busy
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// Prescaler plus free-running PWM period counter; tick/wrap are combinational from the registers.
// Counter advances one step per tick; no backpressure.
module pwm_tick_gen
  import pwm_light_pkg::*;
#(
  parameter int PRESCALE = 100,
  parameter int PERIOD   = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic [CNT_W-1:0] o_counter,
  output logic             o_tick,
  output logic             o_wrap
);

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [PW-1:0] presc_q;

  assign o_tick = (presc_q == PRE_MAX);
  assign o_wrap = o_tick && (o_counter == CNT_MAX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q   <= '0;
      o_counter <= '0;
    end else begin
      presc_q <= o_tick ? '0 : presc_q + 1'b1;
      if (o_wrap)
        o_counter <= '0;
      else if (o_tick)
        o_counter <= o_counter + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_light_ctrl.sv
// Brightness level select, duty fade sequencer and registered PWM compare for one light.
// Level/target one cycle after a button pulse, duty steps only on period wraps, PWM one cycle after counter; no backpressure.
module pwm_light_ctrl
  import pwm_light_pkg::*;
#(
  parameter int PRESCALE     = 100,
  parameter int PERIOD       = 1000,
  parameter int FADE_PERIODS = 4,
  parameter int FADE_STEP    = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pwm_light_ctrl_if.master bus
);

  localparam int               FW      = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [FW-1:0]    FP_MAX  = FW'(FADE_PERIODS - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVEL_NUM - 1);
  localparam logic [CNT_W:0]   STEP11  = (CNT_W + 1)'(FADE_STEP);
  localparam logic [CNT_W-1:0] STEP10  = CNT_W'(FADE_STEP);

  logic [CNT_W-1:0] counter;
  logic             tick;
  logic             wrap;

  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  fade_state_t      state_q, state_d;
  logic             pwm_q;
  logic [CNT_W:0]   up_sum;
  logic [CNT_W:0]   dn_floor;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE),
    .PERIOD   (PERIOD)
  ) u_tick_gen (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .o_counter (counter),
    .o_tick    (tick),
    .o_wrap    (wrap)
  );

  wrap_on_tick: assert property (@(posedge i_clk) disable iff (i_reset) wrap |-> tick);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level_q  <= '0;
      target_q <= '0;
      duty_q   <= '0;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      pwm_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      pwm_q    <= (counter < duty_q);
    end
  end

  always_comb begin
    level_d  = level_q;
    duty_d   = duty_q;
    fcnt_d   = fcnt_q;
    state_d  = IDLE;
    up_sum   = {1'b0, duty_q} + STEP11;
    dn_floor = {1'b0, target_q} + STEP11;

    if (bus.i_btn_off)
      level_d = '0;
    else if (bus.i_btn_next)
      level_d = (level_q == LVL_MAX) ? '0 : level_q + 1'b1;
    target_d = level_duty(level_d, PERIOD);

    // Duty only moves on a wrap so a period never mixes two duty values.
    if (wrap && state_q != IDLE) begin
      if (fcnt_q == FP_MAX) begin
        fcnt_d = '0;
        if (state_q == UP)
          duty_d = (up_sum > {1'b0, target_q}) ? target_q : up_sum[CNT_W-1:0];
        else
          duty_d = ({1'b0, duty_q} < dn_floor) ? target_q : duty_q - STEP10;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // State tracks the next-cycle duty/target so busy never lags a retarget.
    if (duty_d == target_d) begin
      state_d = IDLE;
      fcnt_d  = '0;
    end else if (duty_d < target_d) begin
      state_d = UP;
    end else begin
      state_d = DOWN;
    end
  end

  assign bus.o_counter = counter;
  assign bus.o_pwm     = pwm_q;
  assign bus.o_level   = level_q;
  assign bus.o_duty    = duty_q;
  assign bus.o_busy    = (state_q != IDLE);

endmodule
